// File: rtl/mem_handshake_ctrl_if.sv
// Memory handshake bus between the microprogrammed control unit (master) and the
// memory engine (slave): MFA/R/W/MAS request fields, MAR/MDR data and MFC return.
interface mem_handshake_ctrl_if;
    logic        mfa;
    logic        rw;
    logic [1:0]  mas;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mfc;
    logic        busy;
    logic        align_err;

    modport master (
        output mfa, rw, mas, addr, data_in,
        input  data_out, mfc, busy, align_err
    );

    modport slave (
        input  mfa, rw, mas, addr, data_in,
        output data_out, mfc, busy, align_err
    );
endinterface

// File: rtl/mem_handshake_ctrl.sv
// Byte-addressed big-endian RAM behind an MFA/MFC handshake with programmable wait states.
// Define MEM_ALIGN_CHECK_EN to build the misalignment flag (align_err); otherwise it is tied low.
module mem_handshake_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    mem_handshake_ctrl_if.slave  bus
);
    localparam int MEM_BYTES = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [1:0]          mas_q, mas_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         data_out_q, data_out_d;

    logic [7:0]          mem [MEM_BYTES];
    logic                do_access;
    logic [31:0]         rdata;
    logic [ADDR_W-1:0]   h0, h1, w0, w1, w2, w3;

    // Address bits above ADDR_W are intentionally dropped so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:ADDR_W];

    // Forced-aligned byte lanes; aligned bases never cross the top of the array.
    assign h0 = {addr_q[ADDR_W-1:1], 1'b0};
    assign h1 = {addr_q[ADDR_W-1:1], 1'b1};
    assign w0 = {addr_q[ADDR_W-1:2], 2'b00};
    assign w1 = {addr_q[ADDR_W-1:2], 2'b01};
    assign w2 = {addr_q[ADDR_W-1:2], 2'b10};
    assign w3 = {addr_q[ADDR_W-1:2], 2'b11};

    assign do_access = (state_q == ST_WAIT) && bus.mfa && (cnt_q == 4'd0) && !clr;

    always_comb begin
        unique case (mas_q)
            2'b00:   rdata = {24'h0, mem[addr_q]};
            2'b01:   rdata = {16'h0, mem[h0], mem[h1]};
            default: rdata = {mem[w0], mem[w1], mem[w2], mem[w3]};
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
`endif

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        mas_d      = mas_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.mfa) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                    addr_d  = bus.addr[ADDR_W-1:0];
                    rw_d    = bus.rw;
                    mas_d   = bus.mas;
                    wdata_d = bus.data_in;
`ifdef MEM_ALIGN_CHECK_EN
                    misalign_d = ((bus.mas == 2'b01) && bus.addr[0]) ||
                                 (bus.mas[1] && (bus.addr[1:0] != 2'b00));
`endif
                end
            end
            ST_WAIT: begin
                if (!bus.mfa) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    if (rw_q) data_out_d = rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (!bus.mfa) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            mas_q      <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            mas_q      <= mas_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // NOTE: the array has no reset; clearing it would turn the RAM into a huge flop bank.
    always_ff @(posedge clk) begin
        if (do_access && !rw_q) begin
            unique case (mas_q)
                2'b00: mem[addr_q] <= wdata_q[7:0];
                2'b01: begin
                    mem[h0] <= wdata_q[15:8];
                    mem[h1] <= wdata_q[7:0];
                end
                default: begin
                    mem[w0] <= wdata_q[31:24];
                    mem[w1] <= wdata_q[23:16];
                    mem[w2] <= wdata_q[15:8];
                    mem[w3] <= wdata_q[7:0];
                end
            endcase
        end
    end

    assign bus.mfc      = (state_q == ST_DONE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.data_out = data_out_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign bus.align_err = (state_q == ST_DONE) && misalign_q;
`else
    assign bus.align_err = 1'b0;
`endif
endmodule
